// File: rtl/du_pkg.sv
// Shared debug-unit definitions: dump FSM states, word geometry, default data-memory size
// and the byte-select / checksum helpers used by the memory dump path.
package du_pkg;

  localparam int BYTES_PER_WORD = 32'sd4;
  localparam int DU_MEM_BYTES   = 32'sd256;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SEND  = 3'd2,
    TRAIL = 3'd3,
    DONE  = 3'd4
  } du_state_e;

  // Little-endian byte select: index 0 is the least significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  function automatic logic [7:0] checksum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/du_word_serializer.sv
// Loads a 32-bit word and presents its bytes LSB-first on a valid/ready byte stream.
// A single-byte load presents only the low byte (used for the checksum trailer).
module du_word_serializer
  import du_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_load,
  input  logic        i_single,
  input  logic [31:0] i_word,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last_acc
);

  logic [31:0] word_r;
  logic [1:0]  idx_r;
  logic [7:0]  data_r;
  logic        valid_r;
  logic        accept_s;

  assign accept_s   = valid_r & i_ready;
  assign o_last_acc = accept_s & (idx_r == 2'd3);
  assign o_data     = data_r;
  assign o_valid    = valid_r;

  // Byte sequencing: a load wins, otherwise advance only when the byte is accepted
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      word_r  <= 32'd0;
      idx_r   <= 2'd0;
      data_r  <= 8'd0;
      valid_r <= 1'b0;
    end else if (i_load) begin
      word_r  <= i_word;
      data_r  <= i_word[7:0];
      valid_r <= 1'b1;
      idx_r   <= i_single ? 2'd3 : 2'd0;
    end else if (accept_s) begin
      if (idx_r == 2'd3) begin
        valid_r <= 1'b0;
      end else begin
        idx_r  <= idx_r + 2'd1;
        data_r <= word_byte(word_r, idx_r + 2'd1);
      end
    end
  end

endmodule

// File: rtl/du_mem_dump.sv
// Debug-unit data memory dump: walks memory word by word and streams it as bytes to the DU TX path.
// Optional checksum trailer byte (XOR of all data bytes) enabled by defining DU_DUMP_CHECKSUM_EN.
module du_mem_dump
  import du_pkg::*;
#(
  parameter int MEM_BYTES = DU_MEM_BYTES,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic [ADDR_W-1:0] o_du_mem_addr,
  input  logic [DATA_W-1:0] i_du_mem_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_BYTES - BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD);

  du_state_e         state_r;
  du_state_e         next_state_s;
  logic [ADDR_W-1:0] addr_r;
  logic              busy_r;
  logic              done_r;
  logic              load_s;
  logic              single_s;
  logic [31:0]       load_word_s;
  logic              last_acc_s;
  logic              at_last_s;

  assign at_last_s = (addr_r == LAST_ADDR);

`ifdef DU_DUMP_CHECKSUM_EN
  logic [7:0] acc_r;
  logic [7:0] acc_next_s;
  assign acc_next_s = checksum_step(acc_r, o_tx_data);
`endif

  // Next-state logic and serializer load control
  always_comb begin
    next_state_s = state_r;
    load_s       = 1'b0;
    single_s     = 1'b0;
    load_word_s  = i_du_mem_data[31:0];
    case (state_r)
      IDLE: begin
        if (i_start) next_state_s = LOAD;
        else         next_state_s = IDLE;
      end
      LOAD: begin
        next_state_s = SEND;
        load_s       = 1'b1;
      end
      SEND: begin
        if (last_acc_s) begin
          if (at_last_s) begin
`ifdef DU_DUMP_CHECKSUM_EN
            // Trailer is loaded on the same edge that retires the last data byte
            next_state_s = TRAIL;
            load_s       = 1'b1;
            single_s     = 1'b1;
            load_word_s  = {24'd0, acc_next_s};
`else
            next_state_s = DONE;
`endif
          end else begin
            next_state_s = LOAD;
          end
        end else begin
          next_state_s = SEND;
        end
      end
      TRAIL: begin
        if (last_acc_s) next_state_s = DONE;
        else            next_state_s = TRAIL;
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register, word address walk and status flags
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= IDLE;
      addr_r  <= {ADDR_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
      if (state_r == SEND && last_acc_s && !at_last_s) begin
        addr_r <= addr_r + ADDR_STEP;
      end else if (state_r == IDLE || state_r == DONE) begin
        addr_r <= {ADDR_W{1'b0}};
      end
    end
  end

`ifdef DU_DUMP_CHECKSUM_EN
  // Running XOR of every accepted data byte of the current dump
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      acc_r <= 8'd0;
    end else if (state_r == IDLE) begin
      acc_r <= 8'd0;
    end else if (state_r == SEND && o_tx_valid && i_tx_ready) begin
      acc_r <= acc_next_s;
    end
  end
`endif

  du_word_serializer u_ser (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (load_s),
    .i_single   (single_s),
    .i_word     (load_word_s),
    .i_ready    (i_tx_ready),
    .o_data     (o_tx_data),
    .o_valid    (o_tx_valid),
    .o_last_acc (last_acc_s)
  );

  assign o_du_mem_addr = addr_r;
  assign o_busy        = busy_r;
  assign o_done        = done_r;

endmodule
